// File: rtl/key_debounce.sv
// key_debounce: debounces a raw active-low key pin and generates press, release
// and long-press event pulses. Every output is registered.
module key_debounce #(
    parameter int unsigned DEB_CYCLES  = 1_000_000,
    parameter int unsigned LONG_CYCLES = 50_000_000
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic key,
    output logic key_filter,
    output logic key_press,
    output logic key_release,
    output logic key_long
);

    localparam int unsigned DEB_W  = $clog2(DEB_CYCLES);
    localparam int unsigned LONG_W = $clog2(LONG_CYCLES);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
    localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_DEB,
        PRESSED,
        RELEASE_DEB
    } state_t;

    state_t              state, state_next;
    logic                sync1, key_sync;
    logic [DEB_W-1:0]    deb_cnt, deb_next;
    logic [LONG_W-1:0]   long_cnt, long_next;
    logic                long_done, done_next;
    logic                filter_next, press_next, release_next, long_pulse_next;

    // Two-flop synchronizer; idles high so reset looks like a released key.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            sync1    <= 1'b1;
            key_sync <= 1'b1;
        end else begin
            sync1    <= key;
            key_sync <= sync1;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state       <= IDLE;
            deb_cnt     <= '0;
            long_cnt    <= '0;
            long_done   <= 1'b0;
            key_filter  <= 1'b1;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_long    <= 1'b0;
        end else begin
            state       <= state_next;
            deb_cnt     <= deb_next;
            long_cnt    <= long_next;
            long_done   <= done_next;
            key_filter  <= filter_next;
            key_press   <= press_next;
            key_release <= release_next;
            key_long    <= long_pulse_next;
        end
    end

    // Next-state, counter and output-pulse decode.
    always_comb begin
        state_next      = state;
        deb_next        = deb_cnt;
        long_next       = long_cnt;
        done_next       = long_done;
        filter_next     = key_filter;
        press_next      = 1'b0;
        release_next    = 1'b0;
        long_pulse_next = 1'b0;
        case (state)
            IDLE: begin
                filter_next = 1'b1;
                if (!key_sync) begin
                    state_next = PRESS_DEB;
                    deb_next   = '0;
                end
            end
            PRESS_DEB: begin
                if (key_sync) begin
                    state_next = IDLE;
                    deb_next   = '0;
                end else if (deb_cnt == DEB_LAST) begin
                    state_next  = PRESSED;
                    deb_next    = '0;
                    filter_next = 1'b0;
                    press_next  = 1'b1;
                    long_next   = '0;
                    done_next   = 1'b0;
                end else begin
                    deb_next = deb_cnt + DEB_W'(1);
                end
            end
            PRESSED: begin
                // The long-press check is independent of the release edge so a
                // long event landing on the same edge as a release is still issued.
                if (!long_done) begin
                    if (long_cnt == LONG_LAST) begin
                        long_pulse_next = 1'b1;
                        done_next       = 1'b1;
                    end else if (!key_sync) begin
                        long_next = long_cnt + LONG_W'(1);
                    end
                end
                if (key_sync) begin
                    state_next = RELEASE_DEB;
                    deb_next   = '0;
                end
            end
            RELEASE_DEB: begin
                if (!key_sync) begin
                    state_next = PRESSED;
                    deb_next   = '0;
                end else if (deb_cnt == DEB_LAST) begin
                    state_next   = IDLE;
                    deb_next     = '0;
                    filter_next  = 1'b1;
                    release_next = 1'b1;
                end else begin
                    deb_next = deb_cnt + DEB_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: directed tests of key_debounce with DEB_CYCLES=8, LONG_CYCLES=40.
module tb_key_debounce;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b0;
    logic key     = 1'b1;
    logic key_filter, key_press, key_release, key_long;

    int n_checks = 0;
    int n_fail   = 0;

    // Event recorder state, written only by the monitor below.
    int   edge_n     = 0;
    int   press_cnt  = 0, release_cnt = 0, long_cnt = 0, rise_cnt = 0, low_cnt = 0;
    int   press_edge = -1, release_edge = -1, long_edge = -1, fall_edge = -1, rise_edge = -1;
    logic prev_filter = 1'b1;

    int b_press, b_release, b_long, b_rise, b_low;
    int t0, t1, t2, t3;

    key_debounce #(
        .DEB_CYCLES (8),
        .LONG_CYCLES(40)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .key        (key),
        .key_filter (key_filter),
        .key_press  (key_press),
        .key_release(key_release),
        .key_long   (key_long)
    );

    always #5 sys_clk = ~sys_clk;

    // Count rising edges so events can be located by edge number.
    always @(posedge sys_clk) edge_n <= edge_n + 1;

    // Record pulses and key_filter transitions (outputs sampled mid-cycle).
    always @(negedge sys_clk) begin
        prev_filter <= key_filter;
        if (!sys_rst) begin
            if (key_press)   begin press_cnt   <= press_cnt + 1;   press_edge   <= edge_n; end
            if (key_release) begin release_cnt <= release_cnt + 1; release_edge <= edge_n; end
            if (key_long)    begin long_cnt    <= long_cnt + 1;    long_edge    <= edge_n; end
            if (prev_filter && !key_filter) fall_edge <= edge_n;
            if (!prev_filter && key_filter) begin rise_cnt <= rise_cnt + 1; rise_edge <= edge_n; end
            if (!key_filter) low_cnt <= low_cnt + 1;
        end
    end

    // Drive key for exactly n sampling edges; ends 1 time unit after a falling edge.
    task automatic hold(input logic v, input int n);
        key = v;
        repeat (n) @(negedge sys_clk);
        #1;
    endtask

    task automatic snapshot();
        b_press = press_cnt; b_release = release_cnt; b_long = long_cnt;
        b_rise = rise_cnt; b_low = low_cnt;
    endtask

    task automatic test_reset();
        key = 1'b1;
        #1 sys_rst = 1'b1;
        repeat (3) @(negedge sys_clk);
        #1;
        n_checks++; if (key_filter !== 1'b1) begin n_fail++; $display("FAIL rst_filter: got %b expected 1", key_filter); end
        n_checks++; if (key_press !== 1'b0) begin n_fail++; $display("FAIL rst_press: got %b expected 0", key_press); end
        n_checks++; if (key_release !== 1'b0) begin n_fail++; $display("FAIL rst_release: got %b expected 0", key_release); end
        n_checks++; if (key_long !== 1'b0) begin n_fail++; $display("FAIL rst_long: got %b expected 0", key_long); end
        sys_rst = 1'b0;
        snapshot();
        hold(1'b1, 100);
        n_checks++; if (press_cnt + release_cnt + long_cnt - b_press - b_release - b_long !== 0) begin
            n_fail++; $display("FAIL idle_pulses: got %0d expected 0", press_cnt + release_cnt + long_cnt - b_press - b_release - b_long); end
        n_checks++; if (low_cnt - b_low !== 0) begin n_fail++; $display("FAIL idle_filter_low: got %0d expected 0", low_cnt - b_low); end
        n_checks++; if (key_filter !== 1'b1) begin n_fail++; $display("FAIL idle_filter: got %b expected 1", key_filter); end
    endtask

    task automatic test_press();
        snapshot();
        t0 = edge_n + 1;
        hold(1'b0, 45);
        n_checks++; if (press_cnt - b_press !== 1) begin n_fail++; $display("FAIL press_count: got %0d expected 1", press_cnt - b_press); end
        n_checks++; if (press_edge !== t0 + 10) begin n_fail++; $display("FAIL press_edge: got %0d expected %0d", press_edge, t0 + 10); end
        n_checks++; if (fall_edge !== t0 + 10) begin n_fail++; $display("FAIL filter_fall_edge: got %0d expected %0d", fall_edge, t0 + 10); end
        n_checks++; if (key_filter !== 1'b0) begin n_fail++; $display("FAIL press_filter: got %b expected 0", key_filter); end
        n_checks++; if (long_cnt - b_long !== 0) begin n_fail++; $display("FAIL early_long: got %0d expected 0", long_cnt - b_long); end
        n_checks++; if (release_cnt - b_release !== 0) begin n_fail++; $display("FAIL early_release: got %0d expected 0", release_cnt - b_release); end
        hold(1'b0, 10);
        n_checks++; if (long_cnt - b_long !== 1) begin n_fail++; $display("FAIL long_count: got %0d expected 1", long_cnt - b_long); end
        n_checks++; if (long_edge !== t0 + 50) begin n_fail++; $display("FAIL long_edge: got %0d expected %0d", long_edge, t0 + 50); end
        t1 = edge_n + 1;
        hold(1'b1, 20);
        n_checks++; if (release_cnt - b_release !== 1) begin n_fail++; $display("FAIL release_count: got %0d expected 1", release_cnt - b_release); end
        n_checks++; if (release_edge !== t1 + 10) begin n_fail++; $display("FAIL release_edge: got %0d expected %0d", release_edge, t1 + 10); end
        n_checks++; if (rise_edge !== t1 + 10) begin n_fail++; $display("FAIL filter_rise_edge: got %0d expected %0d", rise_edge, t1 + 10); end
        n_checks++; if (key_filter !== 1'b1) begin n_fail++; $display("FAIL release_filter: got %b expected 1", key_filter); end
    endtask

    task automatic test_press_bounce();
        snapshot();
        hold(1'b0, 5);
        hold(1'b1, 3);
        hold(1'b0, 4);
        hold(1'b1, 20);
        n_checks++; if (low_cnt - b_low !== 0) begin n_fail++; $display("FAIL bounce_filter_low: got %0d expected 0", low_cnt - b_low); end
        n_checks++; if (press_cnt - b_press !== 0) begin n_fail++; $display("FAIL bounce_press: got %0d expected 0", press_cnt - b_press); end
        n_checks++; if (release_cnt + long_cnt - b_release - b_long !== 0) begin
            n_fail++; $display("FAIL bounce_other_pulses: got %0d expected 0", release_cnt + long_cnt - b_release - b_long); end
    endtask

    task automatic test_release_bounce();
        snapshot();
        t0 = edge_n + 1;
        hold(1'b0, 60);
        hold(1'b1, 2);
        hold(1'b0, 3);
        t2 = edge_n + 1;
        hold(1'b1, 20);
        n_checks++; if (press_cnt - b_press !== 1) begin n_fail++; $display("FAIL rb_press_count: got %0d expected 1", press_cnt - b_press); end
        n_checks++; if (long_cnt - b_long !== 1) begin n_fail++; $display("FAIL rb_long_count: got %0d expected 1", long_cnt - b_long); end
        n_checks++; if (long_edge !== t0 + 50) begin n_fail++; $display("FAIL rb_long_edge: got %0d expected %0d", long_edge, t0 + 50); end
        n_checks++; if (release_cnt - b_release !== 1) begin n_fail++; $display("FAIL rb_release_count: got %0d expected 1", release_cnt - b_release); end
        n_checks++; if (release_edge !== t2 + 10) begin n_fail++; $display("FAIL rb_release_edge: got %0d expected %0d", release_edge, t2 + 10); end
        n_checks++; if (rise_cnt - b_rise !== 1) begin n_fail++; $display("FAIL rb_filter_rises: got %0d expected 1", rise_cnt - b_rise); end
        n_checks++; if (rise_edge !== t2 + 10) begin n_fail++; $display("FAIL rb_rise_edge: got %0d expected %0d", rise_edge, t2 + 10); end
    endtask

    task automatic test_reset_mid();
        t0 = edge_n + 1;
        hold(1'b0, 20);
        n_checks++; if (key_filter !== 1'b0) begin n_fail++; $display("FAIL mid_pressed: got %b expected 0", key_filter); end
        snapshot();
        sys_rst = 1'b1;
        #1;
        n_checks++; if (key_filter !== 1'b1) begin n_fail++; $display("FAIL mid_async_filter: got %b expected 1", key_filter); end
        repeat (2) @(negedge sys_clk);
        #1;
        sys_rst = 1'b0;
        t3 = edge_n + 1;
        hold(1'b0, 30);
        n_checks++; if (press_cnt - b_press !== 1) begin n_fail++; $display("FAIL mid_repress_count: got %0d expected 1", press_cnt - b_press); end
        n_checks++; if (press_edge !== t3 + 10) begin n_fail++; $display("FAIL mid_repress_edge: got %0d expected %0d", press_edge, t3 + 10); end
        n_checks++; if (release_cnt - b_release !== 0) begin n_fail++; $display("FAIL mid_no_release: got %0d expected 0", release_cnt - b_release); end
        hold(1'b1, 20);
    endtask

    task automatic test_long_hold();
        snapshot();
        t0 = edge_n + 1;
        hold(1'b0, 100);
        n_checks++; if (press_cnt - b_press !== 1) begin n_fail++; $display("FAIL lh_press_count: got %0d expected 1", press_cnt - b_press); end
        n_checks++; if (long_cnt - b_long !== 1) begin n_fail++; $display("FAIL lh_long_count: got %0d expected 1", long_cnt - b_long); end
        n_checks++; if (long_edge !== t0 + 50) begin n_fail++; $display("FAIL lh_long_edge: got %0d expected %0d", long_edge, t0 + 50); end
        n_checks++; if (release_cnt - b_release !== 0) begin n_fail++; $display("FAIL lh_early_release: got %0d expected 0", release_cnt - b_release); end
        hold(1'b1, 20);
        n_checks++; if (release_cnt - b_release !== 1) begin n_fail++; $display("FAIL lh_release_count: got %0d expected 1", release_cnt - b_release); end
        n_checks++; if (long_cnt - b_long !== 1) begin n_fail++; $display("FAIL lh_long_after_release: got %0d expected 1", long_cnt - b_long); end
    endtask

    initial begin
        test_reset();
        test_press();
        test_press_bounce();
        test_release_bounce();
        test_reset_mid();
        test_long_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/key_debounce.md
Name: key_debounce

Overview:
- Front end for all push-button inputs.
- Takes the raw, asynchronous, bouncing active-low key pin and produces the debounced level `key_filter`, which downstream consumers (e.g. beeper toggle logic) edge-detect.
- Also provides single-cycle press, release and long-press event pulses, so new consumers need no edge detector of their own.
- One instance per key.

Parameters:
- DEB_CYCLES, 1_000_000, consecutive stable sys_clk cycles required to accept a level change (20 ms @ 50 MHz); legal range ≥ 2.
- LONG_CYCLES, 50_000_000, cycles of confirmed hold before long-press event (1 s @ 50 MHz); must be > DEB_CYCLES.

Ports:
- sys_clk  input  1  system clock
- sys_rst  input  1  asynchronous reset, active-high
- key  input  1  raw key pin, active-low (0 = pressed), asynchronous to sys_clk
- key_filter  output  1  debounced key level, active-low, idle 1
- key_press  output  1  one-cycle pulse on confirmed press
- key_release  output  1  one-cycle pulse on confirmed release
- key_long  output  1  one-cycle pulse once per press after LONG_CYCLES of confirmed hold

Behaviour:
- Reset (sys_rst=1, asynchronous):
  - state = IDLE; both synchronizer flops = 1; deb_cnt = 0; long_cnt = 0; long_done = 0.
  - key_filter = 1; key_press = key_release = key_long = 0.
  - Reset dominates every other event.
- Synchronizer:
  - 2-flop chain on key gives key_sync.
  - The FSM only ever looks at key_sync, never at key.
- Counter widths: deb_cnt and long_cnt widths are derived internally from DEB_CYCLES/LONG_CYCLES via $clog2. No overflow is possible; both counters stop at their terminal value.
- All outputs are registered.
- FSM states:
  - IDLE (key_filter=1):
    - key_sync==0 → PRESS_DEB, deb_cnt=0.
  - PRESS_DEB:
    - key_sync==1 → IDLE, deb_cnt=0 (bounce rejected; no pulse).
    - Else if deb_cnt==DEB_CYCLES-1 → PRESSED: key_filter←0, key_press←1 for one cycle, long_cnt←0, long_done←0.
    - Else deb_cnt++.
  - PRESSED (key_filter=0):
    - key_sync==1 → RELEASE_DEB, deb_cnt=0.
    - Otherwise, while long_done==0: long_cnt++.
    - When long_cnt==LONG_CYCLES-1 and long_done==0: key_long←1 for one cycle, long_done←1.
  - RELEASE_DEB:
    - key_sync==0 → PRESSED, deb_cnt=0. This is a release bounce: key_filter stays 0, long_cnt/long_done are kept (not cleared), and no pulse is produced.
    - Else if deb_cnt==DEB_CYCLES-1 → IDLE: key_filter←1, key_release←1 for one cycle.
    - Else deb_cnt++.
    - long_cnt does not advance in this state.
- Latency:
  - Key held low, with the first rising edge that samples key=0 counted as edge 1: key_filter falls and key_press asserts on edge DEB_CYCLES+3.
  - Release is symmetric: key_filter rises and key_release asserts on edge DEB_CYCLES+3.
  - key_long asserts LONG_CYCLES edges after key_filter falls, provided there is no release bounce in between.
- Pulse rules:
  - key_press coincides with the key_filter 1→0 edge; key_release coincides with the 0→1 edge.
  - At most one key_long per press.
  - key_long never coincides with key_press (guaranteed by LONG_CYCLES > DEB_CYCLES ≥ 2).
  - key_long can coincide with a PRESSED→RELEASE_DEB transition only if both occur on the same edge. In that case key_long is still issued.
- Glitches: any bounce shorter than DEB_CYCLES synchronized cycles restarts the count and leaves key_filter unchanged.
- Reset mid-operation:
  - Outputs return to their idle values immediately; no key_release is generated.
  - If key is still held low after reset deasserts, a full debounce runs and key_press is reported again.

Test Plan (DEB_CYCLES=8, LONG_CYCLES=40):
- Reset with key=1 held → key_filter=1 and all pulses 0 throughout; after release of sys_rst, outputs stay idle for 100 cycles.
- key driven low and held → key_filter falls and key_press pulses exactly once, on edge 11 after the first low sample; key_release and key_long stay 0 until 40 cycles later.
- Press bounce: key low 5 cycles, high 3, low 4, high → no change on key_filter, no pulses.
- Clean press, hold 60 cycles, then release with a 3-cycle low bounce 2 cycles into the release →
  - exactly one key_press and one key_long (40 cycles after key_filter falls);
  - exactly one key_release, 11 edges after the final high sample;
  - key_filter stays 0 through the bounce.
- Hold key low, assert sys_rst during PRESSED for 2 cycles, keep key low → key_filter returns to 1 asynchronously; after reset, a fresh key_press after 11 edges; no key_release.
- Hold 100 cycles → exactly one key_long, then no further pulses until release.
